mux_rr_arbiter: RTL and testbench
=================================

MUX_RR_ARBITER -- requirements
Module: mux_rr_arbiter

Interface
REQ-001 The block SHALL have parameter WIDTH, default 2, giving the data width of each source and of the output.
REQ-002 The block SHALL have parameter MAX_HOLD, default 8, giving the maximum number of consecutive grant cycles under contention; legal range is 2..255.
REQ-003 Port clk, input, 1 bit: the single clock; all state changes on the rising edge.
REQ-004 Port rst, input, 1 bit: reset, synchronous, active-high.
REQ-005 Port req, input, 4 bits: request lines; bit i belongs to source i.
REQ-006 Ports in_a, in_b, in_c, in_d, input, WIDTH bits each: source data for indices 0, 1, 2 and 3.
REQ-007 Port gnt, output, 4 bits: registered one-hot grant, all zero when idle.
REQ-008 Port sel, output, 2 bits: registered index of the current or last owner; it drives the 4:1 mux select.
REQ-009 Port out, output, WIDTH bits: registered mux output.
REQ-010 Port out_valid, output, 1 bit: out holds the data of a granted source.

Function
REQ-011 The FSM SHALL have two states, IDLE and GRANT, with a 2-bit round-robin pointer ptr and a hold counter hold_cnt.
REQ-012 The winner SHALL be the first index i with req[i]=1, searched in the order ptr, ptr+1, ptr+2, ptr+3, all modulo 4.
REQ-013 In IDLE, if req is non-zero at an edge, that edge SHALL set gnt to the winner's one-hot code, set sel to the winner's index, clear hold_cnt and enter GRANT (latency is 1 cycle from req to gnt).
REQ-014 In IDLE, if req is zero at an edge, gnt SHALL stay 0 and sel SHALL hold its value.
REQ-015 In GRANT with owner k, if req[k]=0 at an edge, that edge SHALL set ptr to k+1 mod 4 and arbitrate among the remaining requesters from the new ptr.
- If a winner exists, gnt and sel switch to it directly, with no idle bubble, and hold_cnt clears.
- If no winner exists, gnt goes to 0 and the FSM enters IDLE.
REQ-016 In GRANT with req[k]=1 and hold_cnt < MAX_HOLD-1, the grant SHALL be held and hold_cnt SHALL increment.
REQ-017 Timeout: in GRANT with req[k]=1 and hold_cnt = MAX_HOLD-1:
- If any other req bit is set, ptr becomes k+1 and the grant switches to the next winner as in REQ-015.
- If no other req bit is set, the owner keeps the grant and hold_cnt clears to 0.
REQ-018 A request line SHALL NOT receive the grant unless it was asserted at the deciding edge; gnt SHALL never have more than one bit set.
REQ-019 Data path: at each edge where gnt was non-zero before the edge, out SHALL load in_[sel] and out_valid SHALL be set to 1.
REQ-020 At an edge where gnt was zero before the edge, out_valid SHALL be cleared to 0 and out SHALL hold its value; out_valid therefore lags gnt by exactly one cycle.
REQ-021 Simultaneous release and new request from the same source at one edge is not possible; a source that drops req and re-asserts it later SHALL re-enter arbitration at the normal round-robin position.

Reset
REQ-022 When rst=1 at an edge, the block SHALL set state=IDLE, ptr=0, hold_cnt=0, gnt=0, sel=0, out=0 and out_valid=0.
REQ-023 Reset SHALL take priority over every other event, including a GRANT in progress and a timeout occurring on the same edge.
REQ-024 After rst deasserts, the first arbitration SHALL use ptr=0.

Configuration
REQ-025 With macro MUX_ARB_TIMEOUT_EN defined, REQ-016 and REQ-017 SHALL apply as written.
REQ-026 With MUX_ARB_TIMEOUT_EN undefined, the hold_cnt logic SHALL be omitted, MAX_HOLD SHALL be ignored, and the owner SHALL keep the grant until its req drops.

Verification
REQ-027 Reset then single request: rst for 2 cycles, then req=4'b0100 with in_c=2'd3 -> gnt=4'b0100 and sel=2 one cycle later; out=3 and out_valid=1 one cycle after that.
REQ-028 Round-robin order: req=4'b1111 held, each owner dropping and re-raising its req after 3 cycles of grant -> grant order is 0,1,2,3,0 with no idle cycle between grants.
REQ-029 Timeout (macro defined, MAX_HOLD=8): req=4'b0011 held constantly -> source 0 holds for 8 cycles, then source 1 for 8 cycles, then source 0 again.
REQ-030 Timeout without contention: req=4'b0001 for 20 cycles -> gnt=4'b0001 continuously, and gnt does not glitch at cycle 8.
REQ-031 Macro undefined: req=4'b0011 held for 30 cycles -> gnt=4'b0001 for all 30 cycles.
REQ-032 Reset mid-grant: source 2 granted, rst pulsed for 1 cycle -> gnt=0, sel=0, out=0, out_valid=0 at that edge; the next grant goes to the lowest requesting index.

Source files
------------

// File: rtl/mux_rr_arbiter.sv
// Four-source round-robin arbiter driving a registered 4:1 data mux.
// Define MUX_ARB_TIMEOUT_EN to enable the MAX_HOLD grant timeout under contention.
module mux_rr_arbiter #(
  parameter int unsigned WIDTH    = 2,
  parameter int unsigned MAX_HOLD = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [3:0]       req,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic [WIDTH-1:0] in_c,
  input  logic [WIDTH-1:0] in_d,
  output logic [3:0]       gnt,
  output logic [1:0]       sel,
  output logic [WIDTH-1:0] out,
  output logic             out_valid
);

  typedef enum logic {IDLE, GRANT} state_t;

  state_t     state;
  logic [1:0] ptr;
  logic [1:0] rel_ptr;
  logic [1:0] win_idle;
  logic [1:0] win_rel;

  if (MAX_HOLD < 2 || MAX_HOLD > 255) begin : g_bad_hold
    $error("MAX_HOLD out of range 2..255");
  end

  // First requester at or after p, wrapping modulo 4.
  function automatic logic [1:0] pick(input logic [3:0] r, input logic [1:0] p);
    logic [1:0] idx;
    logic       found;
    pick  = p;
    found = 1'b0;
    for (int unsigned i = 0; i < 4; i++) begin
      idx = p + i[1:0];
      if (!found && r[idx]) begin
        pick  = idx;
        found = 1'b1;
      end
    end
  endfunction

  always_comb begin
    rel_ptr  = sel + 2'd1;
    win_idle = pick(req, ptr);
    win_rel  = pick(req, rel_ptr);
  end

`ifdef MUX_ARB_TIMEOUT_EN
  logic [7:0] hold_cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      ptr       <= '0;
      hold_cnt  <= '0;
      gnt       <= '0;
      sel       <= '0;
      out       <= '0;
      out_valid <= 1'b0;
    end else begin
      if (|gnt) begin
        case (sel)
          2'd0:    out <= in_a;
          2'd1:    out <= in_b;
          2'd2:    out <= in_c;
          default: out <= in_d;
        endcase
        out_valid <= 1'b1;
      end else begin
        out_valid <= 1'b0;
      end
      case (state)
        IDLE: begin
          if (|req) begin
            gnt      <= 4'b0001 << win_idle;
            sel      <= win_idle;
            hold_cnt <= '0;
            state    <= GRANT;
          end
        end
        default: begin
          if (!req[sel]) begin
            ptr <= rel_ptr;
            if (|req) begin
              gnt      <= 4'b0001 << win_rel;
              sel      <= win_rel;
              hold_cnt <= '0;
            end else begin
              gnt   <= '0;
              state <= IDLE;
            end
          end else if (hold_cnt == 8'(MAX_HOLD - 1)) begin
            // Owner is still in the search order (last), so win_rel picks another source.
            if (|(req & ~gnt)) begin
              ptr <= rel_ptr;
              gnt <= 4'b0001 << win_rel;
              sel <= win_rel;
            end
            hold_cnt <= '0;
          end else begin
            hold_cnt <= hold_cnt + 8'd1;
          end
        end
      endcase
    end
  end
`else
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      ptr       <= '0;
      gnt       <= '0;
      sel       <= '0;
      out       <= '0;
      out_valid <= 1'b0;
    end else begin
      if (|gnt) begin
        case (sel)
          2'd0:    out <= in_a;
          2'd1:    out <= in_b;
          2'd2:    out <= in_c;
          default: out <= in_d;
        endcase
        out_valid <= 1'b1;
      end else begin
        out_valid <= 1'b0;
      end
      case (state)
        IDLE: begin
          if (|req) begin
            gnt   <= 4'b0001 << win_idle;
            sel   <= win_idle;
            state <= GRANT;
          end
        end
        default: begin
          if (!req[sel]) begin
            ptr <= rel_ptr;
            if (|req) begin
              gnt <= 4'b0001 << win_rel;
              sel <= win_rel;
            end else begin
              gnt   <= '0;
              state <= IDLE;
            end
          end
        end
      endcase
    end
  end
`endif

endmodule

// File: tb/tb_mux_rr_arbiter.sv
// Directed and randomized checks of mux_rr_arbiter against a behavioural round-robin model.
module tb_mux_rr_arbiter;

  localparam int W  = 2;
  localparam int MH = 8;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic [3:0]   req = '0;
  logic [W-1:0] in_a = '0, in_b = '0, in_c = '0, in_d = '0;
  logic [3:0]   gnt;
  logic [1:0]   sel;
  logic [W-1:0] out;
  logic         out_valid;

  int tests = 0;
  int fails = 0;

  mux_rr_arbiter #(.WIDTH(W), .MAX_HOLD(MH)) dut (
    .clk(clk), .rst(rst), .req(req),
    .in_a(in_a), .in_b(in_b), .in_c(in_c), .in_d(in_d),
    .gnt(gnt), .sel(sel), .out(out), .out_valid(out_valid)
  );

  always #5 clk = ~clk;

  // Reference model: owner index, pointer and hold count as plain integers.
  bit           m_idle = 1'b1;
  int           m_owner = 0;
  int           m_ptr = 0;
  int           m_hold = 0;
  logic [3:0]   m_gnt = '0;
  logic [1:0]   m_sel = '0;
  logic [W-1:0] m_out = '0;
  logic         m_ov = 1'b0;

  function automatic int winner(input logic [3:0] r, input int p);
    for (int j = 0; j < 4; j++)
      if (r[(p + j) % 4]) return (p + j) % 4;
    return -1;
  endfunction

  task automatic m_grant(input int w);
    m_owner = w;
    m_gnt   = 4'(1 << w);
    m_sel   = 2'(w);
    m_hold  = 0;
  endtask

  task automatic model_step();
    logic [W-1:0] d [4];
    int w;
    d = '{in_a, in_b, in_c, in_d};
    if (rst) begin
      m_idle = 1'b1; m_owner = 0; m_ptr = 0; m_hold = 0;
      m_gnt = '0; m_sel = '0; m_out = '0; m_ov = 1'b0;
      return;
    end
    if (m_gnt != 0) begin
      m_out = d[m_sel];
      m_ov  = 1'b1;
    end else begin
      m_ov = 1'b0;
    end
    if (m_idle) begin
      if (req != 0) begin
        m_grant(winner(req, m_ptr));
        m_idle = 1'b0;
      end
    end else if (!req[m_owner]) begin
      m_ptr = (m_owner + 1) % 4;
      w = winner(req, m_ptr);
      if (w >= 0) m_grant(w);
      else begin
        m_gnt  = '0;
        m_idle = 1'b1;
      end
    end else begin
`ifdef MUX_ARB_TIMEOUT_EN
      if (m_hold == MH - 1) begin
        if ((req & ~m_gnt) != 0) begin
          m_ptr = (m_owner + 1) % 4;
          m_grant(winner(req, m_ptr));
        end
        m_hold = 0;
      end else begin
        m_hold++;
      end
`endif
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  // Apply inputs (already set on the negedge), clock, then compare 1 time unit after the edge.
  task automatic tick(input logic r, input logic [3:0] rq);
    rst = r;
    req = rq;
    @(posedge clk);
    model_step();
    #1;
    chk("gnt", 32'(gnt), 32'(m_gnt));
    chk("sel", 32'(sel), 32'(m_sel));
    chk("out", 32'(out), 32'(m_out));
    chk("out_valid", 32'(out_valid), 32'(m_ov));
    chk("gnt_onehot0", 32'($onehot0(gnt)), 32'd1);
    @(negedge clk);
  endtask

  initial begin
    int owned;
    logic [3:0] prev_m, prev_g, rq;
    int order [$];

    @(negedge clk);
    // Reset, then a single request from source 2.
    tick(1'b1, 4'b0000);
    tick(1'b1, 4'b0000);
    chk("reset_gnt", 32'(gnt), 32'd0);
    chk("reset_out_valid", 32'(out_valid), 32'd0);
    in_c = 2'd3;
    tick(1'b0, 4'b0100);
    chk("single_gnt", 32'(gnt), 32'h4);
    chk("single_sel", 32'(sel), 32'd2);
    tick(1'b0, 4'b0100);
    chk("single_out", 32'(out), 32'd3);
    chk("single_valid", 32'(out_valid), 32'd1);

    // Reset while source 2 owns the grant; next grant goes to lowest requester.
    tick(1'b1, 4'b0100);
    chk("midrst_gnt", 32'(gnt), 32'd0);
    chk("midrst_sel", 32'(sel), 32'd0);
    chk("midrst_out", 32'(out), 32'd0);
    tick(1'b0, 4'b0110);
    chk("midrst_next", 32'(gnt), 32'h2);

    // Round-robin: all requesting, each owner drops for one cycle after 3 grant cycles.
    tick(1'b1, 4'b0000);
    owned = 0; prev_m = '0; prev_g = '0;
    for (int c = 0; c < 14; c++) begin
      rq = 4'hF;
      if (m_gnt != 0 && owned >= 3) rq[m_sel] = 1'b0;
      tick(1'b0, rq);
      if (gnt != prev_g && gnt != 0) order.push_back(int'(sel));
      prev_g = gnt;
      owned  = (m_gnt == prev_m) ? owned + 1 : 1;
      prev_m = m_gnt;
    end
    chk("rr_count", 32'(order.size() >= 5), 32'd1);
    for (int i = 0; i < 5 && i < order.size(); i++)
      chk("rr_order", 32'(order[i]), 32'(i % 4));

    // Two sources held constantly (timeout alternation when enabled).
    tick(1'b1, 4'b0000);
    for (int c = 0; c < 30; c++) tick(1'b0, 4'b0011);
    // Single source held: no glitch at the hold boundary.
    tick(1'b1, 4'b0000);
    for (int c = 0; c < 20; c++) begin
      tick(1'b0, 4'b0001);
      chk("solo_gnt", 32'(gnt), 32'h1);
    end

    // Randomized traffic with occasional resets.
    rq = 4'($urandom_range(0, 15));
    for (int c = 0; c < 500; c++) begin
      in_a = W'($urandom); in_b = W'($urandom);
      in_c = W'($urandom); in_d = W'($urandom);
      if ($urandom_range(0, 3) == 0) rq = 4'($urandom_range(0, 15));
      tick($urandom_range(0, 39) == 0, rq);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
